// File: rtl/sound_arbiter.sv
// Three-source arbiter for the shared piezo: one pending slot per source,
// effect-first priority with round-robin between tracks, tick-timed notes and gaps.
module sound_arbiter #(
  parameter int HIT_MS = 100,
  parameter int GAP_MS = 5,
  parameter int MIN_MS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic [2:0]  i_req,
  input  logic [31:0] i_pitch_t1,
  input  logic [31:0] i_pitch_t2,
  input  logic [31:0] i_pitch_fx,
  input  logic [7:0]  i_dur_fx,
  input  logic        i_mute,
  output logic        o_play_en,
  output logic [31:0] o_cnt_limit,
  output logic [1:0]  o_active_src,
  output logic [7:0]  o_drop_cnt,
  output logic [1:0]  dbg_state
);

  // Requests are fire-and-forget pulses: no ready/valid handshake exists. A pulse
  // always lands in its slot; an occupied, ungranted slot is overwritten and counted.
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

  localparam logic [15:0] HIT_W = 16'(HIT_MS);
  localparam logic [15:0] GAP_W = 16'(GAP_MS);
  localparam logic [15:0] MIN_W = 16'(MIN_MS);

  state_t      state, state_n;
  logic [2:0]  slot_vld;
  logic [31:0] pitch_t1, pitch_t2, pitch_fx;
  logic [7:0]  dur_fx;
  logic        ptr;          // 0: Track 1 is favoured next, 1: Track 2
  logic [15:0] timer;
  logic [15:0] elapsed;
  logic [15:0] gap_cnt;

  logic        grant;
  logic [1:0]  gsel;
  logic [2:0]  gmask;
  logic [2:0]  drops;
  logic [1:0]  ndrop;
  logic [8:0]  drop_sum;
  logic [15:0] gdur;
  logic [31:0] gpitch;

  assign dbg_state = state;

  always_comb begin
    gsel = 2'd0;
    if (slot_vld[2])         gsel = 2'd2;
    else if (slot_vld[ptr])  gsel = {1'b0, ptr};
    else if (slot_vld[~ptr]) gsel = {1'b0, ~ptr};
  end

  assign grant = (|slot_vld) &&
                 ((state == IDLE) || ((state == PLAY) && (elapsed >= MIN_W)));
  assign gmask = grant ? (3'b001 << gsel) : 3'b000;

  // Same-cycle grant of a slot frees it, so a fresh pulse there is not a drop.
  assign drops    = i_req & slot_vld & ~gmask;
  assign ndrop    = {1'b0, drops[0]} + {1'b0, drops[1]} + {1'b0, drops[2]};
  assign drop_sum = {1'b0, o_drop_cnt} + {7'd0, ndrop};

  always_comb begin
    gdur   = HIT_W;
    gpitch = pitch_t1;
    case (gsel)
      2'd1:    gpitch = pitch_t2;
      2'd2: begin
        gpitch = pitch_fx;
        gdur   = {8'd0, dur_fx};
      end
      default: gpitch = pitch_t1;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant) state_n = PLAY;
      PLAY:    if (!grant && i_tick && (timer == 16'd1)) state_n = GAP;
      GAP:     if ((gap_cnt == 16'd0) || (i_tick && (gap_cnt == 16'd1))) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      slot_vld     <= 3'b000;
      pitch_t1     <= '0;
      pitch_t2     <= '0;
      pitch_fx     <= '0;
      dur_fx       <= '0;
      ptr          <= 1'b0;
      timer        <= '0;
      elapsed      <= '0;
      gap_cnt      <= '0;
      o_play_en    <= 1'b0;
      o_cnt_limit  <= '0;
      o_active_src <= 2'd0;
      o_drop_cnt   <= '0;
    end else begin
      state    <= state_n;
      slot_vld <= (slot_vld & ~gmask) | i_req;
      if (i_req[0]) pitch_t1 <= i_pitch_t1;
      if (i_req[1]) pitch_t2 <= i_pitch_t2;
      if (i_req[2]) begin
        pitch_fx <= i_pitch_fx;
        dur_fx   <= (i_dur_fx == 8'd0) ? 8'd1 : i_dur_fx;
      end
      if (ndrop != 2'd0)
        o_drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];

      if (grant) begin
        timer        <= gdur;
        elapsed      <= '0;
        o_cnt_limit  <= gpitch;
        o_active_src <= (gsel == 2'd2) ? 2'd3 : gsel + 2'd1;
        if (gsel != 2'd2) ptr <= ~gsel[0];
      end else if ((state == PLAY) && i_tick) begin
        timer <= timer - 16'd1;
        if (elapsed < MIN_W) elapsed <= elapsed + 16'd1;
        if (state_n == GAP) begin
          gap_cnt      <= GAP_W;
          o_active_src <= 2'd0;
        end
      end else if ((state == GAP) && i_tick && (gap_cnt != 16'd0)) begin
        gap_cnt <= gap_cnt - 16'd1;
      end

      o_play_en <= (state_n == PLAY) && !i_mute;
    end
  end

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter: a note-level behavioural model checked every
// cycle, plus literal expectations at the points the scenarios call out.
module tb_sound_arbiter;

  localparam int HIT = 100;
  localparam int GAPT = 5;
  localparam int MINT = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tick = 1'b0;
  logic [2:0]  i_req = 3'b000;
  logic [31:0] i_pitch_t1 = '0, i_pitch_t2 = '0, i_pitch_fx = '0;
  logic [7:0]  i_dur_fx = '0;
  logic        i_mute = 1'b0;
  logic        o_play_en;
  logic [31:0] o_cnt_limit;
  logic [1:0]  o_active_src;
  logic [7:0]  o_drop_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  sound_arbiter #(.HIT_MS(HIT), .GAP_MS(GAPT), .MIN_MS(MINT)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_req(i_req),
    .i_pitch_t1(i_pitch_t1), .i_pitch_t2(i_pitch_t2), .i_pitch_fx(i_pitch_fx),
    .i_dur_fx(i_dur_fx), .i_mute(i_mute),
    .o_play_en(o_play_en), .o_cnt_limit(o_cnt_limit),
    .o_active_src(o_active_src), .o_drop_cnt(o_drop_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a note is either sounding, in its gap, or nothing is.
  int          m_phase;      // 0 silent, 1 sounding, 2 gap
  bit          m_pend[3];
  logic [31:0] m_pitch[3];
  int          m_fxdur;
  int          m_rr;         // track index favoured next (0 or 1)
  int          m_left, m_played, m_gapleft;
  logic        m_en;
  logic [31:0] m_lim;
  logic [1:0]  m_src;
  int          m_drop;
  int          m_pick;
  bit          m_took[3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_rr = 0; m_left = 0; m_played = 0; m_gapleft = 0;
      m_en = 0; m_lim = 0; m_src = 0; m_drop = 0; m_fxdur = 0;
      for (int k = 0; k < 3; k++) begin m_pend[k] = 0; m_pitch[k] = 0; end
    end else begin
      m_pick = -1;
      for (int k = 0; k < 3; k++) m_took[k] = 0;
      if (m_pend[2]) m_pick = 2;
      else if (m_pend[m_rr]) m_pick = m_rr;
      else if (m_pend[1 - m_rr]) m_pick = 1 - m_rr;
      if (m_pick >= 0 && (m_phase == 0 || (m_phase == 1 && m_played >= MINT))) begin
        m_took[m_pick] = 1;
        m_pend[m_pick] = 0;
        m_phase = 1;
        m_played = 0;
        m_left = (m_pick == 2) ? m_fxdur : HIT;
        m_lim = m_pitch[m_pick];
        m_src = (m_pick == 2) ? 2'd3 : 2'(m_pick + 1);
        if (m_pick < 2) m_rr = 1 - m_pick;
      end else if (m_phase == 1 && i_tick) begin
        m_left--; m_played++;
        if (m_left == 0) begin m_phase = 2; m_gapleft = GAPT; m_src = 0; end
      end else if (m_phase == 2) begin
        if (m_gapleft == 0) m_phase = 0;
        else if (i_tick) begin
          m_gapleft--;
          if (m_gapleft == 0) m_phase = 0;
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (i_req[k]) begin
          if (m_pend[k] && !m_took[k] && m_drop < 255) m_drop++;
          m_pend[k] = 1;
        end
      end
      if (i_req[0]) m_pitch[0] = i_pitch_t1;
      if (i_req[1]) m_pitch[1] = i_pitch_t2;
      if (i_req[2]) begin
        m_pitch[2] = i_pitch_fx;
        m_fxdur = (i_dur_fx == 0) ? 1 : int'(i_dur_fx);
      end
      m_en = (m_phase == 1) && !i_mute;
    end
  end

  // Per-cycle compare against the model, on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("play_en", {31'd0, o_play_en}, {31'd0, m_en});
      chk("cnt_limit", o_cnt_limit, m_lim);
      chk("active_src", {30'd0, o_active_src}, {30'd0, m_src});
      chk("drop_cnt", {24'd0, o_drop_cnt}, m_drop[31:0]);
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 i_tick = 1'b1;
      @(posedge clk); #1 i_tick = 1'b0;
    end
  endtask

  task automatic send(input logic [2:0] req, input logic [31:0] p1, input logic [31:0] p2,
                      input logic [31:0] pfx, input logic [7:0] dur);
    @(posedge clk); #1;
    i_req = req; i_pitch_t1 = p1; i_pitch_t2 = p2; i_pitch_fx = pfx; i_dur_fx = dur;
    @(posedge clk); #1 i_req = 3'b000;
  endtask

  task automatic do_reset;
    @(posedge clk); #1 rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    #1;
    chk("rst_play_en", {31'd0, o_play_en}, 32'd0);
    chk("rst_limit", o_cnt_limit, 32'd0);
    chk("rst_src", {30'd0, o_active_src}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // Single Track 1 hit
    send(3'b001, 32'd1000, 32'd0, 32'd0, 8'd0);
    cyc(1);
    chk("t1_en", {31'd0, o_play_en}, 32'd1);
    chk("t1_limit", o_cnt_limit, 32'd1000);
    chk("t1_src", {30'd0, o_active_src}, 32'd1);
    tick_n(99);
    chk("t1_en_tick99", {31'd0, o_play_en}, 32'd1);
    tick_n(1);
    chk("t1_en_tick100", {31'd0, o_play_en}, 32'd0);
    chk("t1_gap_state", {30'd0, dbg_state}, 32'd2);
    chk("t1_limit_held", o_cnt_limit, 32'd1000);
    tick_n(4);
    chk("t1_gap4_state", {30'd0, dbg_state}, 32'd2);
    tick_n(1);
    chk("t1_idle_state", {30'd0, dbg_state}, 32'd0);

    // Effect priority and round robin
    do_reset();
    send(3'b111, 32'd11, 32'd22, 32'd33, 8'd3);
    cyc(1);
    chk("rr_fx_src", {30'd0, o_active_src}, 32'd3);
    chk("rr_fx_limit", o_cnt_limit, 32'd33);
    tick_n(3 + GAPT);
    cyc(1);
    chk("rr_t1_src", {30'd0, o_active_src}, 32'd1);
    chk("rr_t1_limit", o_cnt_limit, 32'd11);
    tick_n(HIT + GAPT);
    cyc(1);
    chk("rr_t2_src", {30'd0, o_active_src}, 32'd2);
    chk("rr_t2_limit", o_cnt_limit, 32'd22);
    chk("rr_drop", {24'd0, o_drop_cnt}, 32'd0);
    tick_n(HIT + GAPT);
    cyc(1);
    chk("rr_idle", {30'd0, dbg_state}, 32'd0);

    // Preemption after the minimum play time
    do_reset();
    send(3'b001, 32'd1000, 32'd0, 32'd0, 8'd0);
    cyc(1);
    tick_n(10);
    send(3'b010, 32'd0, 32'd2000, 32'd0, 8'd0);
    tick_n(9);
    chk("pre_wait_src", {30'd0, o_active_src}, 32'd1);
    tick_n(1);
    cyc(1);
    chk("pre_src", {30'd0, o_active_src}, 32'd2);
    chk("pre_limit", o_cnt_limit, 32'd2000);
    chk("pre_en", {31'd0, o_play_en}, 32'd1);
    tick_n(HIT + GAPT);
    cyc(1);

    // Overwrite and saturating drop count
    do_reset();
    send(3'b001, 32'd1000, 32'd0, 32'd0, 8'd0);
    cyc(1);
    send(3'b010, 32'd0, 32'd500, 32'd0, 8'd0);
    send(3'b010, 32'd0, 32'd700, 32'd0, 8'd0);
    chk("drop_one", {24'd0, o_drop_cnt}, 32'd1);
    tick_n(MINT);
    cyc(1);
    chk("drop_play_limit", o_cnt_limit, 32'd700);
    chk("drop_play_src", {30'd0, o_active_src}, 32'd2);
    for (int i = 0; i < 301; i++) send(3'b010, 32'd0, 32'(i + 1), 32'd0, 8'd0);
    chk("drop_sat", {24'd0, o_drop_cnt}, 32'd255);
    tick_n(HIT + GAPT);
    cyc(1);

    // Zero-length effect under mute
    do_reset();
    i_mute = 1'b1;
    send(3'b100, 32'd0, 32'd0, 32'd77, 8'd0);
    cyc(1);
    chk("mute_en", {31'd0, o_play_en}, 32'd0);
    chk("mute_src", {30'd0, o_active_src}, 32'd3);
    chk("mute_limit", o_cnt_limit, 32'd77);
    tick_n(1);
    chk("fx1_src_after", {30'd0, o_active_src}, 32'd0);
    chk("fx1_gap", {30'd0, dbg_state}, 32'd2);
    tick_n(GAPT);
    i_mute = 1'b0;
    cyc(1);

    // Reset mid-note with a pending request
    do_reset();
    send(3'b001, 32'd1234, 32'd0, 32'd0, 8'd0);
    cyc(1);
    send(3'b011, 32'd1500, 32'd1600, 32'd0, 8'd0);
    tick_n(3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", {31'd0, o_play_en}, 32'd0);
    chk("mid_rst_limit", o_cnt_limit, 32'd0);
    chk("mid_rst_src", {30'd0, o_active_src}, 32'd0);
    chk("mid_rst_drop", {24'd0, o_drop_cnt}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick_n(10);
    chk("post_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("post_rst_en", {31'd0, o_play_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
